vector_packer: RTL and testbench
================================

Name: vector_packer

Overview:
- Deserialising stage that sits directly downstream of the byte-serialiser in the matrix datapath.
- Collects a stream of 8-bit elements, one per accepted cycle, into a SIZE-lane packed vector.
- Presents completed vectors on a valid/ready output toward the result writeback path.
- Holds one assembly vector plus one output vector, so sustained 1 byte/cycle input is possible while the consumer keeps up.

Parameters:
SIZE, 4, number of 8-bit lanes per vector (>=2); index width IW = $clog2(SIZE)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  data_in carries an element this cycle
in_ready  output  1  packer can accept an element this cycle
data_in  input  8  element; lane order 0 first
flush  input  1  force out a partially filled vector
out_valid  output  1  data_out holds a complete vector
out_ready  input  1  consumer takes data_out this cycle
data_out  output  [SIZE-1:0][7:0]  packed vector, lane k = k-th element received
partial  output  1  qualifies data_out: vector was produced by flush (upper lanes zero)
vec_count  output  16  number of vectors transferred out (out_valid&&out_ready), wraps 0xFFFF->0

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values:
  - idx=0, asm_full=0, asm_data=0.
  - out_valid=0, data_out=0, partial=0, vec_count=0.
  - A reset mid-vector discards the partial vector and any held vector.
- Internal state:
  - idx: next lane to write.
  - asm_data: SIZE lanes.
  - asm_full: assembly register holds a finished vector awaiting the output slot.
  - asm_part: partial flag for that held vector.
- in_ready = !asm_full (combinational from state only, not from in_valid).
- accept = in_valid && in_ready. On accept, data_in is written into lane idx.
- Vector completion:
  - complete = accept && idx==SIZE-1, or flush && !asm_full && (idx!=0 || accept).
  - On completion, idx<=0.
  - The completed vector is asm_data with the current accepted byte merged in; unwritten lanes are 0.
- Flush rules:
  - Flush with accept at idx==SIZE-1 is a normal full vector, partial=0.
  - Flush with accept at any other idx includes that byte, partial=1.
  - Flush with idx==0 and no accept: ignored.
  - Flush while asm_full: ignored, and not remembered.
- slot_free = !out_valid || out_ready.
- Priority per cycle:
  1. asm_full && slot_free: data_out<=asm_data, partial<=asm_part, out_valid<=1, asm_full<=0, asm_data<=0. No completion can occur this cycle, since in_ready=0.
  2. complete && slot_free: data_out<=merged vector, partial per flush rule, out_valid<=1, asm_data<=0.
  3. complete && !slot_free: asm_data<=merged vector, asm_full<=1, asm_part set.
  4. Otherwise, out_valid && out_ready: out_valid<=0. data_out and partial hold their last values.
- Latency and throughput:
  - The completing byte accepted in cycle t gives out_valid=1 in cycle t+1.
  - With out_ready held at 1, throughput is one vector per SIZE cycles and in_ready never drops.
- Stall behaviour:
  - While out_valid=1 && out_ready=0, data_out and partial are stable.
  - Input continues into assembly until the next vector completes; then in_ready=0 until the output slot frees.
- vec_count increments on every out_valid && out_ready, independent of the partial flag.
- Elements presented while in_ready=0 are not consumed; the upstream holds them.

Test Plan:
- Basic pack (SIZE=4): out_ready=1, bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> one cycle later out_valid=1, data_out lanes[0..3]=11,22,33,44, partial=0, vec_count=1 the cycle after.
- Back-to-back stream: 8 consecutive bytes 0x01..0x08, out_ready=1 -> vectors {01,02,03,04} then {05,06,07,08} four cycles apart; in_ready stays 1 throughout.
- Backpressure: out_ready=0, send 8 bytes 0xA0..0xA7 -> first vector held on data_out; in_ready=0 after the 8th byte is accepted. Raise out_ready -> second vector appears the next cycle, in_ready returns to 1, vec_count=2 after both transfers.
- Flush partial: bytes 0x5A,0x5B then flush with no valid -> data_out={5A,5B,00,00}, partial=1. A flush with idx==0 -> no out_valid.
- Flush with simultaneous byte: 0x01,0x02 accepted, then 0x03 with flush in the same cycle -> {01,02,03,00}, partial=1. Byte at lane 3 with flush -> full vector, partial=0.
- Reset mid-operation: 2 bytes accepted plus a held vector, then reset -> out_valid=0, in_ready=1, vec_count=0. The next 4 bytes 0xC0..0xC3 produce exactly {C0,C1,C2,C3}.

Source files
------------

// File: rtl/vector_packer.sv
// vector_packer: deserialiser that packs a stream of 8-bit elements into a
// SIZE-lane vector and offers finished vectors on a valid/ready output.
// One assembly vector plus one output vector are held, so a steady
// 1 element/cycle input keeps flowing while the consumer keeps up.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    element handshake, data_in is the element (lane 0 first)
//   flush                push out a partially filled vector (upper lanes zero)
//   out_valid/out_ready  vector handshake, data_out is the packed vector
//   partial              data_out came from a flush and is not full
//   vec_count            count of vectors transferred out, wraps at 16 bits

// One assembly lane: stores its element when selected and presents the
// merged value (the in-flight element overrides the stored one).
module vector_packer_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       clr,
  input  logic [7:0] data_in,
  output logic [7:0] merged,
  output logic [7:0] asm_q
);
  assign merged = sel ? data_in : asm_q;

  // clr wins over sel: the element was already forwarded in merged.
  always_ff @(posedge clk) begin
    if (reset || clr) asm_q <= '0;
    else if (sel)     asm_q <= data_in;
  end
endmodule

module vector_packer #(
  parameter int SIZE = 4,
  parameter int IW   = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           data_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0][7:0] data_out,
  output logic                 partial,
  output logic [15:0]          vec_count
);
  logic [IW-1:0]        idx;
  logic                 asm_full, asm_part;
  logic [SIZE-1:0][7:0] asm_data, merged;
  logic                 accept, last, complete, slot_free, drain, load;

  assign in_ready  = !asm_full;
  assign accept    = in_valid && in_ready;
  assign last      = accept && (idx == IW'(SIZE-1));
  assign complete  = last || (flush && !asm_full && (idx != '0 || accept));
  assign slot_free = !out_valid || out_ready;
  // drain: held vector moves to the output slot; load: fresh vector goes
  // straight to the output slot. drain implies no accept, so no overlap.
  assign drain     = asm_full && slot_free;
  assign load      = complete && slot_free;

  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    vector_packer_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .sel    (accept && (idx == IW'(k))),
      .clr    (drain || load),
      .data_in(data_in),
      .merged (merged[k]),
      .asm_q  (asm_data[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      asm_full  <= 1'b0;
      asm_part  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      partial   <= 1'b0;
      vec_count <= '0;
    end else begin
      if (out_valid && out_ready) vec_count <= vec_count + 16'd1;

      if (drain) begin
        data_out  <= asm_data;
        partial   <= asm_part;
        out_valid <= 1'b1;
        asm_full  <= 1'b0;
      end else if (load) begin
        data_out  <= merged;
        partial   <= !last;
        out_valid <= 1'b1;
        idx       <= '0;
      end else if (complete) begin
        // lanes capture the in-flight element themselves; just mark held
        asm_full  <= 1'b1;
        asm_part  <= !last;
        idx       <= '0;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        if (accept) idx <= idx + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_vector_packer.sv
module tb_vector_packer;
  localparam int SIZE = 4;

  logic                 clk = 1'b0;
  logic                 reset, in_valid, flush, out_ready;
  logic [7:0]           data_in;
  logic                 in_ready, out_valid, partial;
  logic [SIZE-1:0][7:0] data_out;
  logic [15:0]          vec_count;

  vector_packer #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .partial(partial),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: elements gathered so far, an optional held vector,
  // and the output slot.
  logic [7:0]           cur[$];
  logic                 m_ov, m_part, m_held, m_hpart;
  logic [SIZE-1:0][7:0] m_dout, m_hdat;
  logic [15:0]          m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    m_ov = 0; m_part = 0; m_held = 0; m_hpart = 0;
    m_dout = '0; m_hdat = '0; m_cnt = '0;
  endtask

  task automatic model_upd(input logic r, iv, input logic [7:0] d, input logic fl, ordy);
    logic acc, full, cmp, free;
    logic [SIZE-1:0][7:0] v;
    if (r) begin model_reset(); return; end
    acc  = iv && !m_held;
    full = acc && (cur.size() == SIZE-1);
    if (acc) cur.push_back(d);
    cmp  = full || (fl && !m_held && cur.size() != 0);
    free = !m_ov || ordy;
    if (m_ov && ordy) m_cnt++;
    if (m_held && free) begin
      m_dout = m_hdat; m_part = m_hpart; m_ov = 1; m_held = 0;
    end else if (cmp) begin
      v = '0;
      foreach (cur[i]) v[i] = cur[i];
      cur.delete();
      if (free) begin m_dout = v; m_part = !full; m_ov = 1; end
      else      begin m_hdat = v; m_hpart = !full; m_held = 1; end
    end else if (m_ov && ordy) m_ov = 0;
  endtask

  task automatic step(input logic r, iv, input logic [7:0] d, input logic fl, ordy);
    reset = r; in_valid = iv; data_in = d; flush = fl; out_ready = ordy;
    #1;
    if (chk_en) begin
      chk("in_ready",  in_ready,  !m_held);
      chk("out_valid", out_valid, m_ov);
      chk("data_out",  data_out,  m_dout);
      chk("partial",   partial,   m_part);
      chk("vec_count", vec_count, m_cnt);
    end
    @(posedge clk);
    model_upd(r, iv, d, fl, ordy);
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    chk("rst_vec_count", vec_count, 16'd0);
    chk("rst_out_valid", out_valid, 1'b0);

    // basic pack
    step(0, 1, 8'h11, 0, 1); step(0, 1, 8'h22, 0, 1);
    step(0, 1, 8'h33, 0, 1); step(0, 1, 8'h44, 0, 1);
    chk("basic_dout", data_out, 32'h44332211);
    chk("basic_valid", out_valid, 1'b1);
    step(0, 0, 8'h00, 0, 1);
    chk("basic_count", vec_count, 16'd1);

    // back-to-back stream
    for (int i = 1; i <= 8; i++) step(0, 1, 8'(i), 0, 1);
    chk("b2b_dout", data_out, 32'h08070605);
    step(0, 0, 8'h00, 0, 1);

    // backpressure
    for (int i = 0; i < 8; i++) step(0, 1, 8'hA0 + 8'(i), 0, 0);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_first", data_out, 32'hA3A2A1A0);
    step(0, 0, 8'h00, 0, 1);
    chk("bp_second", data_out, 32'hA7A6A5A4);
    chk("bp_ready_back", in_ready, 1'b1);
    step(0, 0, 8'h00, 0, 1);

    // flush partial, then flush at idx 0
    step(0, 1, 8'h5A, 0, 1); step(0, 1, 8'h5B, 0, 1);
    step(0, 0, 8'h00, 1, 1);
    chk("flush_dout", data_out, 32'h00005B5A);
    chk("flush_part", partial, 1'b1);
    step(0, 0, 8'h00, 1, 1);
    chk("flush_idle", out_valid, 1'b0);

    // flush with simultaneous byte
    step(0, 1, 8'h01, 0, 1); step(0, 1, 8'h02, 0, 1);
    step(0, 1, 8'h03, 1, 1);
    chk("flushb_dout", data_out, 32'h00030201);
    chk("flushb_part", partial, 1'b1);
    step(0, 1, 8'h04, 0, 1); step(0, 1, 8'h05, 0, 1);
    step(0, 1, 8'h06, 0, 1); step(0, 1, 8'h07, 1, 1);
    chk("flushf_dout", data_out, 32'h07060504);
    chk("flushf_part", partial, 1'b0);

    // reset mid-operation with a held vector
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 8'h90 + 8'(i), 0, 0);
    step(0, 1, 8'hEE, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    chk("rmid_valid", out_valid, 1'b0);
    chk("rmid_ready", in_ready, 1'b1);
    chk("rmid_count", vec_count, 16'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'hC0 + 8'(i), 0, 1);
    chk("rmid_dout", data_out, 32'hC3C2C1C0);

    // randomized traffic with stall phases
    for (int i = 0; i < 3000; i++) begin
      logic stall;
      stall = ((i / 50) % 3) == 1;
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) != 0,
           8'($urandom),
           $urandom_range(0, 9) == 0,
           stall ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
